// File: rtl/posit_normalize_pipe.sv
// -----------------------------------------------------------------------------
// posit_normalize_pipe
//   Three-stage posit encoder for the ES=2 datapath. Takes the serialized raw
//   value {sgn, scale, fraction, inf, zero} and produces a normalized NBITS-bit
//   posit word. All stages advance together under a single valid/ready
//   handshake.
//
//   Optional build macro: POSIT_ROUND_NEAREST_EN
//     defined   -> round-to-nearest-even on the dropped bits
//     undefined -> truncation of the magnitude (guard/sticky not built)
//   In both builds the magnitude is clamped to [minpos, maxpos].
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears valids and datapath
//   in_data    {sgn, scale[SCALE_W-1:0] (2's compl), fraction[FRAC_W-1:0], inf, zero}
//   in_valid   in_data valid
//   in_ready   stage S1 can load this cycle (global advance)
//   out_posit  encoded posit (registered)
//   out_valid  out_posit valid
//   out_ready  consumer accepts out_posit
// -----------------------------------------------------------------------------
module posit_normalize_pipe #(
  parameter int NBITS   = 32,
  parameter int ES      = 2,
  parameter int SCALE_W = 8,
  parameter int FRAC_W  = 27
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SCALE_W+FRAC_W+2:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [NBITS-1:0]            out_posit,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int STAGES = 3;
  localparam int W      = 64;                 // body working width
  localparam int G      = W - NBITS;          // index of the guard bit in the body
  localparam int PAD    = W - 2 - ES - FRAC_W;
  localparam int K_W    = SCALE_W - ES;       // regime run-length value width
  localparam int SAT_I  = (NBITS - 2) << ES;  // |scale| at which the regime fills the word

  localparam logic signed [SCALE_W-1:0] SAT_HI = SCALE_W'(SAT_I);
  localparam logic signed [SCALE_W-1:0] SAT_LO = SCALE_W'(-SAT_I);

  localparam logic [NBITS-1:0] MAXPOS = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0] MINPOS = NBITS'(1);
  localparam logic [NBITS-1:0] NAR    = {1'b1, {(NBITS-1){1'b0}}};

  typedef struct packed {
    logic              sgn;
    logic [K_W-1:0]    k;
    logic [ES-1:0]     e;
    logic [FRAC_W-1:0] frac;
    logic              inf;
    logic              zero;
    logic              hi;
    logic              lo;
  } s1_t;

  typedef struct packed {
    logic              sgn;
    logic [NBITS-2:0]  kept;
`ifdef POSIT_ROUND_NEAREST_EN
    logic              guard;
    logic              sticky;
`endif
    logic              inf;
    logic              zero;
    logic              hi;
    logic              lo;
  } s2_t;

  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  logic [NBITS-1:0]  res_d, out_q;
  logic [STAGES:1]   vld_pipe;
  logic              adv;

  // A full output stage that is not being taken freezes the whole pipe; empty
  // stages in front of it are not squeezed out while stalled.
  assign adv       = !vld_pipe[STAGES] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign out_posit = out_q;

  // ---------------- S1: field decode ----------------
  logic signed [SCALE_W-1:0] scale;

  always_comb begin
    scale      = in_data[FRAC_W+2 +: SCALE_W];
    s1_d       = '0;
    s1_d.sgn   = in_data[SCALE_W+FRAC_W+2];
    // k = scale >>> ES and e = scale mod 2^ES are just the upper/lower bits
    s1_d.k     = scale[SCALE_W-1:ES];
    s1_d.e     = scale[ES-1:0];
    s1_d.frac  = in_data[FRAC_W+1:2];
    s1_d.inf   = in_data[1];
    s1_d.zero  = in_data[0];
    s1_d.hi    = scale >= SAT_HI;
    s1_d.lo    = scale <= SAT_LO;
  end

  // ---------------- S2: regime + body ----------------
  logic [K_W-1:0] shamt;
  logic [W-1:0]   vec, sh;

  always_comb begin
    // Seed with "10" (k>=0) or "01" (k<0) ahead of {e, frac}, then shift right
    // with sign fill: k>=0 replicates the leading 1 into k+1 ones, k<0 shifts
    // in zeros for a run of -k zeros. For k<0 the shift is -k-1 == ~k.
    shamt = s1_q.k[K_W-1] ? ~s1_q.k : s1_q.k;
    vec   = {(s1_q.k[K_W-1] ? 2'b01 : 2'b10), s1_q.e, s1_q.frac, {PAD{1'b0}}};
    sh    = $signed(vec) >>> shamt;

    s2_d        = '0;
    s2_d.sgn    = s1_q.sgn;
    s2_d.kept   = (NBITS-1)'(sh >> (G + 1));
`ifdef POSIT_ROUND_NEAREST_EN
    s2_d.guard  = sh[G];
    s2_d.sticky = |sh[G-1:0];
`endif
    s2_d.inf    = s1_q.inf;
    s2_d.zero   = s1_q.zero;
    s2_d.hi     = s1_q.hi;
    s2_d.lo     = s1_q.lo;
  end

  // ---------------- S3: round, clamp, specials, sign ----------------
  logic [NBITS-1:0] mag, sel;

  always_comb begin
    mag = {1'b0, s2_q.kept};
`ifdef POSIT_ROUND_NEAREST_EN
    mag = mag + NBITS'(s2_q.guard & (s2_q.kept[0] | s2_q.sticky));
`endif
    // Never round a nonzero value to zero, never carry into the sign bit.
    if (mag == '0)
      mag = MINPOS;
    else if (mag[NBITS-1])
      mag = MAXPOS;

    if (s2_q.hi)
      sel = MAXPOS;
    else if (s2_q.lo)
      sel = MINPOS;
    else
      sel = mag;

    // zero beats inf; neither special is negated
    if (s2_q.zero)
      res_d = '0;
    else if (s2_q.inf)
      res_d = NAR;
    else
      res_d = s2_q.sgn ? -sel : sel;
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      out_q    <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      out_q    <= res_d;
    end
  end

endmodule

// File: tb/tb_posit_normalize_pipe.sv
module tb_posit_normalize_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_posit;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  posit_normalize_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_posit (out_posit),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic logic [37:0] mk(input bit sgn, input int scale, input logic [26:0] frac,
                                     input bit inf, input bit zero);
    logic [7:0] s8;
    s8 = 8'(scale);
    return {sgn, s8, frac, inf, zero};
  endfunction

  // Reference: write the posit as a bit string (regime, exponent, fraction),
  // keep the first 31 bits, then round/clamp and apply the sign.
  function automatic logic [31:0] ref_posit(input logic [37:0] d);
    bit          sgn;
    int          scale, e, k;
    logic [26:0] f;
    bit          q[$];
    longint      kept;
    logic [31:0] m;
    sgn   = d[37];
    scale = $signed(d[36:29]);
    f     = d[28:2];
    if (d[0]) return 32'h0000_0000;
    if (d[1]) return 32'h8000_0000;
    if (scale >= 120) m = 32'h7FFF_FFFF;
    else if (scale <= -120) m = 32'h0000_0001;
    else begin
      e = scale & 3;
      k = (scale - e) / 4;
      if (k >= 0) begin
        for (int i = 0; i < k + 1; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(e[1]);
      q.push_back(e[0]);
      for (int i = 26; i >= 0; i--) q.push_back(f[i]);
      while (q.size() < 64) q.push_back(1'b0);
      kept = 0;
      for (int i = 0; i < 31; i++) kept = (kept << 1) | longint'(q[i]);
`ifdef POSIT_ROUND_NEAREST_EN
      begin
        bit g, st;
        g  = q[31];
        st = 1'b0;
        for (int i = 32; i < q.size(); i++) st = st | q[i];
        if (g && ((kept % 2 == 1) || st)) kept = kept + 1;
      end
`endif
      if (kept == 0) kept = 1;
      if (kept > 64'h7FFF_FFFF) kept = 64'h7FFF_FFFF;
      m = 32'(kept);
    end
    return sgn ? -m : m;
  endfunction

  function automatic logic [37:0] rand_in();
    int scale;
    if ($urandom_range(0, 3) == 0)
      scale = ($urandom_range(0, 1) == 1) ? int'($urandom_range(112, 127)) : -int'($urandom_range(112, 128));
    else
      scale = int'($urandom_range(0, 255)) - 128;
    return mk(1'($urandom), scale, 27'($urandom), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 15) == 0));
  endfunction

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++; if (out_posit !== 32'h0) begin errors++; $display("FAIL reset_posit: got %h want 0", out_posit); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_directed();
    logic [37:0] din[15];
    logic [31:0] dexp[15];
    din[0]  = mk(0, 0, 0, 0, 0);        dexp[0]  = 32'h4000_0000;
    din[1]  = mk(0, 1, 0, 0, 0);        dexp[1]  = 32'h4800_0000;
    din[2]  = mk(0, -1, 0, 0, 0);       dexp[2]  = 32'h3800_0000;
    din[3]  = mk(1, 0, 0, 0, 0);        dexp[3]  = 32'hC000_0000;
    din[4]  = mk(0, 5, 27'h123, 0, 1);  dexp[4]  = 32'h0000_0000;
    din[5]  = mk(1, 3, 0, 1, 0);        dexp[5]  = 32'h8000_0000;
    din[6]  = mk(0, 127, 0, 0, 0);      dexp[6]  = 32'h7FFF_FFFF;
    din[7]  = mk(0, -128, 0, 0, 0);     dexp[7]  = 32'h0000_0001;
    din[8]  = mk(1, 127, 0, 0, 0);      dexp[8]  = 32'h8000_0001;
    din[9]  = mk(0, 4, 27'h1, 0, 0);    dexp[9]  = 32'h6000_0000;
`ifdef POSIT_ROUND_NEAREST_EN
    din[10] = mk(0, 4, 27'h3, 0, 0);    dexp[10] = 32'h6000_0002;
`else
    din[10] = mk(0, 4, 27'h3, 0, 0);    dexp[10] = 32'h6000_0001;
`endif
    din[11] = mk(1, 9, 0, 1, 1);        dexp[11] = 32'h0000_0000;
    din[12] = mk(0, 120, 0, 0, 0);      dexp[12] = 32'h7FFF_FFFF;
    din[13] = mk(1, -120, 0, 0, 0);     dexp[13] = 32'hFFFF_FFFF;
    din[14] = mk(1, 1, 0, 0, 1);        dexp[14] = 32'h0000_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_data = din[i]; in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_ready: got %b want 1", i, in_ready); end
      @(posedge clk);
      @(negedge clk); in_valid = 1'b0; #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_lat1: got %b want 0", i, out_valid); end
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_lat2: got %b want 0", i, out_valid); end
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_lat3: got %b want 1", i, out_valid); end
      checks++; if (out_posit !== dexp[i]) begin errors++; $display("FAIL dir%0d_value: got %h want %h", i, out_posit, dexp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [37:0] d[6];
    logic [31:0] held = '0, e;
    int sent = 0, got = 0, stall = -1, cyc = 0;
    bit stalled_prev = 0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) d[i] = mk(1'($urandom), int'($urandom_range(0, 200)) - 100, 27'($urandom), 0, 0);
    while (got < 6 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (stall < 0 && out_valid) stall = 4;
      out_ready = !(stall > 0);
      if (sent < 6) begin in_valid = 1'b1; in_data = d[sent]; end else in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL bp_ready: got %b want %b", in_ready, !(out_valid && !out_ready)); end
      if (stalled_prev) begin
        checks++; if (out_valid !== 1'b1 || out_posit !== held) begin
          errors++; $display("FAIL bp_stable: got %b/%h want 1/%h", out_valid, out_posit, held); end
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_posit(d[sent])); sent++; end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra: got %h want none", out_posit); end
        else begin
          e = exp_q.pop_front();
          if (out_posit !== e) begin errors++; $display("FAIL bp_order%0d: got %h want %h", got, out_posit, e); end
          got++;
        end
      end
      stalled_prev = out_valid && !out_ready;
      held = out_posit;
      if (stall > 0) stall--;
    end
    checks++; if (got != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", got); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: got %b want 0", out_valid); end
    end
  endtask

  task automatic test_random_stream();
    logic [37:0] d;
    logic [31:0] held = '0, e;
    int sent = 0, got = 0, cyc = 0;
    bit stalled_prev = 0;
    exp_q.delete();
    d = rand_in();
    while ((sent < 400 || exp_q.size() != 0) && cyc < 5000) begin
      @(negedge clk); cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < 400) && ($urandom_range(0, 4) != 0);
      in_data   = d;
      #1;
      checks++; if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL rnd_ready: got %b want %b", in_ready, (!out_valid || out_ready)); end
      if (stalled_prev) begin
        checks++; if (out_valid !== 1'b1 || out_posit !== held) begin
          errors++; $display("FAIL rnd_stable: got %b/%h want 1/%h", out_valid, out_posit, held); end
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_posit(d)); sent++; d = rand_in(); end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra: got %h want none", out_posit); end
        else begin
          e = exp_q.pop_front();
          if (out_posit !== e) begin errors++; $display("FAIL rnd_value%0d: got %h want %h", got, out_posit, e); end
          got++;
        end
      end
      stalled_prev = out_valid && !out_ready;
      held = out_posit;
    end
    checks++; if (got != 400) begin errors++; $display("FAIL rnd_count: got %0d want 400", got); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    logic [37:0] d;
    logic [31:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = rand_in();
    end
    @(posedge clk);
    #2;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_inflight: got %b want 1", out_valid); end
    #1;
    reset = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b want 1", in_ready); end
    checks++; if (out_posit !== 32'h0) begin errors++; $display("FAIL rst_async_posit: got %h want 0", out_posit); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale%0d: got %b want 0", i, out_valid); end
    end
    d = mk(0, 4, 27'h3, 0, 0);
    e = ref_posit(d);
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_new_lat1: got %b want 0", out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_new_lat2: got %b want 0", out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_new_lat3: got %b want 1", out_valid); end
    checks++; if (out_posit !== e) begin errors++; $display("FAIL rst_new_value: got %h want %h", out_posit, e); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random_stream();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
